// File: rtl/micro_ucr_miner_multi.sv
// Multi-lane nonce search for micro-ucr-hash: LANES iterative cores sweep a nonce range,
// lowest valid nonce wins. Define UCR_MINER_STATS_EN to add the hash_count output.
module micro_ucr_miner_multi #(
  parameter int LANES  = 4,
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        active,
  input  logic        start,
  input  logic [95:0] payload,
  input  logic [7:0]  target,
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_end,
  output logic        busy,
  output logic        terminado,
  output logic        found,
  output logic [31:0] nonceOut,
  output logic [23:0] hashOut
`ifdef UCR_MINER_STATS_EN
  ,
  output logic [31:0] hash_count
`endif
);

  localparam int RW = $clog2(ROUNDS);

  typedef enum logic [1:0] {IDLE, HASH, CHECK, DONE} state_t;

  state_t         state_reg;
  logic [RW-1:0]  round_reg;
  logic [31:0]    base_reg;
  logic [31:0]    nonce_end_reg;
  logic [95:0]    payload_reg;
  logic [7:0]     target_reg;
  logic           busy_reg;
  logic           terminado_reg;
  logic           found_reg;
  logic [31:0]    nonce_out_reg;
  logic [23:0]    hash_out_reg;

  logic           accept;
  logic           cont;
  logic           load_lanes;
  logic           step_lanes;
  logic           exhausted;
  logic [32:0]    base_plus_lanes;
  logic [31:0]    load_base;
  logic [95:0]    load_payload;

  logic [23:0]    lane_hash [LANES];
  logic [LANES-1:0] lane_elig;
  logic [LANES-1:0] lane_valid;

  logic           hit;
  logic [31:0]    win_nonce;
  logic [23:0]    win_hash;

  assign accept          = ((state_reg == IDLE) || (state_reg == DONE)) && start;
  assign base_plus_lanes = {1'b0, base_reg} + 33'(LANES);
  assign exhausted       = (({1'b0, base_reg} + 33'(LANES - 1)) >= {1'b0, nonce_end_reg})
                           || base_plus_lanes[32];
  assign cont            = (state_reg == CHECK) && !hit && !exhausted;
  assign load_lanes      = accept || cont;
  assign step_lanes      = (state_reg == HASH);
  // A new search loads lanes straight from the ports, a follow-on batch from the latched copy.
  assign load_base       = accept ? nonce_start : base_plus_lanes[31:0];
  assign load_payload    = accept ? payload : payload_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0]   a_reg, b_reg, c_reg;
      logic [127:0] w_reg;
      logic [7:0]   k_rnd, q_rnd;
      logic [7:0]   h0, h1, h2;

      always_comb begin
        k_rnd = 8'ha1;
        q_rnd = a_reg | b_reg;
        if (round_reg <= RW'(16)) begin
          k_rnd = 8'h99;
          q_rnd = a_reg ^ b_reg;
        end
      end

      // w_reg holds the message window w[i..i+15]; top byte is the word for the current round.
      always_ff @(posedge clk) begin
        if (!active) begin
          a_reg <= '0;
          b_reg <= '0;
          c_reg <= '0;
          w_reg <= '0;
        end else if (load_lanes) begin
          a_reg <= 8'h01;
          b_reg <= 8'h89;
          c_reg <= 8'hfe;
          w_reg <= {load_payload, load_base + 32'(gi)};
        end else if (step_lanes) begin
          a_reg <= b_reg ^ c_reg;
          b_reg <= {c_reg[3:0], 4'h0};
          c_reg <= q_rnd + k_rnd + w_reg[127:120];
          w_reg <= {w_reg[119:0], w_reg[23:16] | (w_reg[71:64] ^ w_reg[111:104])};
        end
      end

      assign h0 = 8'h01 + a_reg;
      assign h1 = 8'h89 + b_reg;
      assign h2 = 8'hfe + c_reg;
      assign lane_hash[gi]  = {h0, h1, h2};
      assign lane_elig[gi]  = ({1'b0, base_reg} + 33'(gi)) <= {1'b0, nonce_end_reg};
      assign lane_valid[gi] = (h0 < target_reg) && (h1 < target_reg);
    end
  endgenerate

  always_comb begin
    hit       = 1'b0;
    win_nonce = '0;
    win_hash  = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      if (lane_elig[j] && lane_valid[j]) begin
        hit       = 1'b1;
        win_nonce = base_reg + 32'(j);
        win_hash  = lane_hash[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!active) begin
      state_reg     <= IDLE;
      round_reg     <= '0;
      base_reg      <= '0;
      nonce_end_reg <= '0;
      payload_reg   <= '0;
      target_reg    <= '0;
      busy_reg      <= 1'b0;
      terminado_reg <= 1'b0;
      found_reg     <= 1'b0;
      nonce_out_reg <= '0;
      hash_out_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            payload_reg   <= payload;
            target_reg    <= target;
            nonce_end_reg <= nonce_end;
            base_reg      <= nonce_start;
            round_reg     <= '0;
            state_reg     <= HASH;
            busy_reg      <= 1'b1;
            terminado_reg <= 1'b0;
            found_reg     <= 1'b0;
            nonce_out_reg <= '0;
            hash_out_reg  <= '0;
          end
        end
        HASH: begin
          round_reg <= round_reg + RW'(1);
          if (round_reg == RW'(ROUNDS - 1)) begin
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            terminado_reg <= 1'b1;
            found_reg     <= 1'b1;
            nonce_out_reg <= win_nonce;
            hash_out_reg  <= win_hash;
          end else if (exhausted) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            terminado_reg <= 1'b1;
          end else begin
            base_reg  <= base_plus_lanes[31:0];
            round_reg <= '0;
            state_reg <= HASH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign terminado = terminado_reg;
  assign found     = found_reg;
  assign nonceOut  = nonce_out_reg;
  assign hashOut   = hash_out_reg;

`ifdef UCR_MINER_STATS_EN
  logic [5:0]  elig_cnt;
  logic [32:0] hc_sum;
  logic [31:0] hash_count_reg;

  always_comb begin
    elig_cnt = '0;
    for (int j = 0; j < LANES; j++) begin
      elig_cnt = elig_cnt + 6'(lane_elig[j]);
    end
  end

  assign hc_sum = {1'b0, hash_count_reg} + 33'(elig_cnt);

  always_ff @(posedge clk) begin
    if (!active || accept) begin
      hash_count_reg <= '0;
    end else if (state_reg == CHECK) begin
      hash_count_reg <= hc_sum[32] ? 32'hffffffff : hc_sum[31:0];
    end
  end

  assign hash_count = hash_count_reg;
`endif

endmodule

// File: tb/tb_micro_ucr_miner_multi.sv
// Randomised self-checking bench for micro_ucr_miner_multi against a linear-search reference model.
module tb_micro_ucr_miner_multi;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        active;
  logic        start;
  logic [95:0] payload;
  logic [7:0]  target;
  logic [31:0] nonce_start;
  logic [31:0] nonce_end;
  logic        busy;
  logic        terminado;
  logic        found;
  logic [31:0] nonceOut;
  logic [23:0] hashOut;
`ifdef UCR_MINER_STATS_EN
  logic [31:0] hash_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  micro_ucr_miner_multi #(.LANES(LANES), .ROUNDS(32)) dut (
    .clk(clk),
    .active(active),
    .start(start),
    .payload(payload),
    .target(target),
    .nonce_start(nonce_start),
    .nonce_end(nonce_end),
    .busy(busy),
    .terminado(terminado),
    .found(found),
    .nonceOut(nonceOut),
    .hashOut(hashOut)
`ifdef UCR_MINER_STATS_EN
    ,
    .hash_count(hash_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Straight transcription of the hash algorithm: full message schedule, then 32 rounds.
  function automatic logic [23:0] ref_hash(input logic [95:0] p, input logic [31:0] n);
    logic [127:0] blk;
    logic [7:0]   w [32];
    logic [7:0]   a, b, c, k, q, na, nb, nc, h0, h1, h2;
    blk = {p, n};
    for (int i = 0; i < 16; i++) w[i] = blk[127 - 8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hfe;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin k = 8'h99; q = a ^ b; end
      else         begin k = 8'ha1; q = a | b; end
      na = b ^ c;
      nb = c << 4;
      nc = q + k + w[i];
      a = na; b = nb; c = nc;
    end
    h0 = 8'h01 + a; h1 = 8'h89 + b; h2 = 8'hfe + c;
    return {h0, h1, h2};
  endfunction

  // Ascending scan of the range; batch count and eligible-hash count derived from where it stops.
  task automatic ref_search(input logic [95:0] p, input logic [7:0] t, input logic [31:0] s,
                            input logic [31:0] e, output logic fnd, output logic [31:0] nn,
                            output logic [23:0] hh, output int batches, output longint cnt);
    longint total;
    longint off;
    logic [23:0] h;
    total = (e < s) ? 0 : (longint'(e) - longint'(s) + 1);
    fnd = 1'b0; nn = '0; hh = '0; off = 0;
    for (longint o = 0; o < total && !fnd; o++) begin
      h = ref_hash(p, s + 32'(o));
      if (h[23:16] < t && h[15:8] < t) begin
        fnd = 1'b1; nn = s + 32'(o); hh = h; off = o;
      end
    end
    if (fnd) begin
      batches = int'(off / LANES) + 1;
      cnt = (longint'(batches) * LANES < total) ? longint'(batches) * LANES : total;
    end else begin
      batches = (total == 0) ? 1 : int'((total + LANES - 1) / LANES);
      cnt = total;
    end
  endtask

  task automatic run_search(input logic [95:0] p, input logic [7:0] t, input logic [31:0] s,
                            input logic [31:0] e, input int pulse_k);
    logic        efnd;
    logic [31:0] enn;
    logic [23:0] ehh;
    int          eb;
    longint      ecnt;
    int          k;
    int          limit;
    ref_search(p, t, s, e, efnd, enn, ehh, eb, ecnt);
    @(negedge clk);
    payload = p; target = t; nonce_start = s; nonce_end = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    check("accept_terminado", terminado, 0);
    check("accept_busy", busy, 1);
    check("accept_found", found, 0);
    check("accept_nonce", nonceOut, 0);
    check("accept_hash", hashOut, 0);
    limit = 33 * eb + 40;
    while (terminado !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
      if (k == pulse_k) begin
        start = 1'b1; nonce_start = s + 32'd1000; payload = ~p; target = 8'hff;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_terminado", terminado, 1);
    check("latency", 64'(k), 64'(33 * eb));
    check("done_busy", busy, 0);
    check("done_found", found, efnd);
    check("done_nonce", nonceOut, enn);
    check("done_hash", hashOut, ehh);
`ifdef UCR_MINER_STATS_EN
    check("hash_count", hash_count, 64'(ecnt));
`endif
    @(negedge clk);
    check("hold_nonce", nonceOut, enn);
    check("hold_terminado", terminado, 1);
    $display("search start=%h end=%h target=%h pulse=%0d found=%0d nonce=%h hash=%h cycles=%0d",
             s, e, t, pulse_k, found, nonceOut, hashOut, k);
  endtask

  initial begin
    logic [95:0] p;
    logic [31:0] s;
    logic [31:0] e;
    longint      el;
    active = 1'b0; start = 1'b0; payload = '0; target = '0; nonce_start = '0; nonce_end = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_terminado", terminado, 0);
    check("reset_found", found, 0);
    check("reset_nonce", nonceOut, 0);
    check("reset_hash", hashOut, 0);
    active = 1'b1;

    p = {$urandom, $urandom, $urandom};
    run_search(p, 8'h00, 32'd0, 32'd15, -1);
    run_search(p, 8'hff, 32'h01001b23, 32'h01001b23 + 32'd63, -1);
    run_search({$urandom, $urandom, $urandom}, 8'h00, 32'd0, 32'd5, -1);
    run_search(p, 8'h00, 32'hfffffffe, 32'hffffffff, -1);
    run_search(p, 8'hff, 32'd100, 32'd50, -1);
    run_search({$urandom, $urandom, $urandom}, 8'h60, $urandom, 32'd0, 7);
    run_search({$urandom, $urandom, $urandom}, 8'h60, 32'h00400000, 32'h00400028, 7);

    // Mid-search reset discards the search; a fresh one must follow cleanly.
    @(negedge clk);
    payload = p; target = 8'hff; nonce_start = 32'h1234; nonce_end = 32'h2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    active = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_terminado", terminado, 0);
    check("midreset_found", found, 0);
    check("midreset_nonce", nonceOut, 0);
    check("midreset_hash", hashOut, 0);
    active = 1'b1;
    run_search(p, 8'h80, 32'h00000777, 32'h00000790, -1);

    for (int i = 0; i < 10; i++) begin
      p = {$urandom, $urandom, $urandom};
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hffffffff - 32'($urandom_range(0, 20));
      el = longint'(s) + longint'($urandom_range(0, 40));
      e = (el > 64'h00000000ffffffff) ? 32'hffffffff : el[31:0];
      if ($urandom_range(0, 7) == 0) e = s - 32'd3;
      run_search(p, 8'($urandom_range(32, 255)), s, e, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
